// File: rtl/npu_setreset_pulse_gen.sv
// SET/RESET pulse sequencer: latches one operation's width and switch windows on start,
// drives the array switches for the pulse, then discharges. Optional nest check: NPU_PULSE_NEST_CHECK_EN.
//
// state     | meaning
// IDLE      | waiting for start; config not latched
// PULSE     | cycle index c runs 0..W, switches follow their windows
// DISCHARGE | DISCHG high for DISCHG_CYCLES cycles, all switches low
module npu_setreset_pulse_gen #(
    parameter int CNT_WIDTH     = 16,
    parameter int DISCHG_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] set_pulse_width,
    input  logic [CNT_WIDTH-1:0] reset_pulse_width,
    input  logic [CNT_WIDTH-1:0] set_wl_st,
    input  logic [CNT_WIDTH-1:0] set_wl_end,
    input  logic [CNT_WIDTH-1:0] set_sel_st,
    input  logic [CNT_WIDTH-1:0] set_sel_end,
    input  logic [CNT_WIDTH-1:0] set_bl_st,
    input  logic [CNT_WIDTH-1:0] set_bl_end,
    input  logic [CNT_WIDTH-1:0] reset_wl_st,
    input  logic [CNT_WIDTH-1:0] reset_wl_end,
    input  logic [CNT_WIDTH-1:0] reset_sel_st,
    input  logic [CNT_WIDTH-1:0] reset_sel_end,
    input  logic [CNT_WIDTH-1:0] reset_bl_st,
    input  logic [CNT_WIDTH-1:0] reset_bl_end,
    output logic                 DACWL_SW,
    output logic                 DACSEL_SW,
    output logic                 DACBL_SW,
    output logic                 SET,
    output logic                 RESET,
    output logic                 DISCHG,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int DW = (DISCHG_CYCLES > 1) ? $clog2(DISCHG_CYCLES) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DISCHG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PULSE, DISCHARGE} state_t;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    state_t  state_q, state_d;
    cnt_t    cnt_q, cnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic    latch;
    logic    mode_q, mode_e;
    cnt_t    w_q, wl_st_q, wl_end_q, sel_st_q, sel_end_q, bl_st_q, bl_end_q;
    cnt_t    sel_w, sel_wl_st, sel_wl_end, sel_sel_st, sel_sel_end, sel_bl_st, sel_bl_end;
    cnt_t    w_e, wl_st_e, wl_end_e, sel_st_e, sel_end_e, bl_st_e, bl_end_e;
    logic    win_err, nest_err;
    logic    wl_d, sel_d, bl_d, set_d, reset_d, dischg_d, busy_d, done_d, err_d;

    function automatic logic win_on(input cnt_t st, input cnt_t en, input cnt_t w, input cnt_t c);
        return (st <= c) && (c <= en) && (c <= w);
    endfunction

    assign sel_w       = mode ? reset_pulse_width : set_pulse_width;
    assign sel_wl_st   = mode ? reset_wl_st   : set_wl_st;
    assign sel_wl_end  = mode ? reset_wl_end  : set_wl_end;
    assign sel_sel_st  = mode ? reset_sel_st  : set_sel_st;
    assign sel_sel_end = mode ? reset_sel_end : set_sel_end;
    assign sel_bl_st   = mode ? reset_bl_st   : set_bl_st;
    assign sel_bl_end  = mode ? reset_bl_end  : set_bl_end;

    assign win_err = (sel_wl_st > sel_wl_end)   || (sel_wl_end > sel_w)  ||
                     (sel_sel_st > sel_sel_end) || (sel_sel_end > sel_w) ||
                     (sel_bl_st > sel_bl_end)   || (sel_bl_end > sel_w);

`ifdef NPU_PULSE_NEST_CHECK_EN
    assign nest_err = !((sel_wl_st <= sel_sel_st) && (sel_sel_st <= sel_bl_st) &&
                        (sel_bl_end <= sel_sel_end) && (sel_sel_end <= sel_wl_end));
`else
    assign nest_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        latch   = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (nest_err) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = PULSE;
                        cnt_d   = '0;
                        latch   = 1'b1;
                        err_d   = win_err;
                    end
                end
            end
            PULSE: begin
                // Exit on equality so a width of all-ones never wraps the index.
                if (abort || (cnt_q == w_q)) begin
                    state_d = DISCHARGE;
                    cnt_d   = '0;
                    dcnt_d  = DCNT_LAST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DISCHARGE: begin
                if (dcnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from next-cycle state and config.
    always_comb begin
        mode_e    = latch ? mode        : mode_q;
        w_e       = latch ? sel_w       : w_q;
        wl_st_e   = latch ? sel_wl_st   : wl_st_q;
        wl_end_e  = latch ? sel_wl_end  : wl_end_q;
        sel_st_e  = latch ? sel_sel_st  : sel_st_q;
        sel_end_e = latch ? sel_sel_end : sel_end_q;
        bl_st_e   = latch ? sel_bl_st   : bl_st_q;
        bl_end_e  = latch ? sel_bl_end  : bl_end_q;
        wl_d      = (state_d == PULSE) && win_on(wl_st_e, wl_end_e, w_e, cnt_d);
        sel_d     = (state_d == PULSE) && win_on(sel_st_e, sel_end_e, w_e, cnt_d);
        bl_d      = (state_d == PULSE) && win_on(bl_st_e, bl_end_e, w_e, cnt_d);
        set_d     = (state_d == PULSE) && !mode_e;
        reset_d   = (state_d == PULSE) && mode_e;
        dischg_d  = (state_d == DISCHARGE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            mode_q    <= 1'b0;
            w_q       <= '0;
            wl_st_q   <= '0;
            wl_end_q  <= '0;
            sel_st_q  <= '0;
            sel_end_q <= '0;
            bl_st_q   <= '0;
            bl_end_q  <= '0;
            DACWL_SW  <= 1'b0;
            DACSEL_SW <= 1'b0;
            DACBL_SW  <= 1'b0;
            SET       <= 1'b0;
            RESET     <= 1'b0;
            DISCHG    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            if (latch) begin
                mode_q    <= mode;
                w_q       <= sel_w;
                wl_st_q   <= sel_wl_st;
                wl_end_q  <= sel_wl_end;
                sel_st_q  <= sel_sel_st;
                sel_end_q <= sel_sel_end;
                bl_st_q   <= sel_bl_st;
                bl_end_q  <= sel_bl_end;
            end
            DACWL_SW  <= wl_d;
            DACSEL_SW <= sel_d;
            DACBL_SW  <= bl_d;
            SET       <= set_d;
            RESET     <= reset_d;
            DISCHG    <= dischg_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule
